// File: rtl/spi_trig_rx.sv
// Passive SPI frame receiver: synchronizes SS_n/SCLK/MOSI, deserializes MSB first,
// and raises a one-cycle protocol trigger when a complete frame matches match/mask.
module spi_trig_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        pos_edge,
  input  logic        width8,
  input  logic [15:0] match,
  input  logic [15:0] mask,
  output logic        SPItrig,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] rx_data,
  output logic        busy
);

  typedef enum logic {IDLE, RX} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_d, sclk_d, mosi_q;
  logic ss_rise_q, ss_fall_q, sclk_rise_q, sclk_fall_q;

  logic [15:0] shift, shift_n, rx_n, diff;
  logic [4:0]  cnt, cnt_n, exp_cnt;
  logic        trig_n, done_n, err_n, sample, hit;

  logic ss_s, sclk_s, mosi_s;
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge flags are registered together with MOSI so the sampled bit stays aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync     <= '0;
      ss_d        <= 1'b0;
      sclk_sync   <= '1;
      sclk_d      <= 1'b1;
      mosi_sync   <= '0;
      mosi_q      <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
    end else begin
      ss_sync     <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d        <= ss_s;
      sclk_d      <= sclk_s;
      mosi_q      <= mosi_s;
      ss_rise_q   <= ss_s & ~ss_d;
      ss_fall_q   <= ~ss_s & ss_d;
      sclk_rise_q <= sclk_s & ~sclk_d;
      sclk_fall_q <= ~sclk_s & sclk_d;
    end
  end

  assign exp_cnt = width8 ? 5'd8 : 5'd16;
  assign diff    = (shift ^ match) & ~mask;
  assign hit     = width8 ? (diff[7:0] == 8'h00) : (diff == 16'h0000);
  assign sample  = pos_edge ? sclk_rise_q : sclk_fall_q;

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    rx_n    = rx_data;
    trig_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall_q) begin
          shift_n = '0;
          cnt_n   = '0;
          state_n = RX;
        end
      end
      RX: begin
        // SS_n rise takes priority; a coincident SCLK edge is dropped.
        if (ss_rise_q) begin
          state_n = IDLE;
          if (cnt == exp_cnt) begin
            done_n = 1'b1;
            trig_n = hit;
            rx_n   = width8 ? {8'h00, shift[7:0]} : shift;
          end else begin
            err_n = 1'b1;
          end
        end else if (sample) begin
          shift_n = {shift[14:0], mosi_q};
          if (cnt != 5'd17) cnt_n = cnt + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      rx_data    <= '0;
      SPItrig    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      cnt        <= cnt_n;
      rx_data    <= rx_n;
      SPItrig    <= trig_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  assign busy = (state == RX);

endmodule
